// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB boundary: result/load-size encodings, payload struct,
// skid FSM states and the sub-word load extraction helper.
package mem_wb_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LINK = 2'b01,
        RES_LO   = 2'b10,
        RES_HI   = 2'b11
    } ressel_e;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10
    } ldsize_e;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'b00,
        SK_ONE   = 2'b01,
        SK_FULL  = 2'b10
    } skid_st_e;

    typedef struct packed {
        logic [DW_DEF-1:0] alures;
        logic [DW_DEF-1:0] memout;
        logic [RW_DEF-1:0] regdst;
        logic [RW_DEF-1:0] rt;
        logic              memtoreg;
        logic              memread;
        logic              regwrite;
    } mem_wb_pl_t;

    // Encoding 2'b11 is unused and treated like a full word.
    function automatic logic [DW_DEF-1:0] ld_extract(
        input logic [DW_DEF-1:0] w,
        input logic [1:0]        sz,
        input logic              sgn,
        input logic [1:0]        lsb
    );
        logic [DW_DEF-1:0] sh;
        logic [7:0]        b;
        logic [15:0]       h;
        sh = '0;
        b  = '0;
        h  = '0;
        case (ldsize_e'(sz))
            LD_B: begin
                sh = w >> (8 * lsb);
                b  = sh[7:0];
                return {{(DW_DEF-8){sgn & b[7]}}, b};
            end
            LD_H: begin
                sh = w >> (16 * lsb[1]);
                h  = sh[15:0];
                return {{(DW_DEF-16){sgn & h[15]}}, h};
            end
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_skid.sv
// Generic 2-entry skid buffer: main slot drives the outputs, skid slot absorbs the
// one extra beat accepted while downstream stalls. Ready is registered.
module mem_wb_skid
    import mem_wb_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [PW-1:0] o_data
);

    skid_st_e      state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          rdy_q;
    logic          accept, pop;

    assign o_valid = (state_q != SK_EMPTY);
    assign o_ready = rdy_q;
    assign o_data  = main_q;
    assign accept  = i_valid & rdy_q & ~i_flush;
    assign pop     = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SK_EMPTY: if (accept) begin
                state_d = SK_ONE;
                main_d  = i_data;
            end
            SK_ONE: begin
                if (accept && pop) begin
                    main_d = i_data;
                end else if (accept) begin
                    state_d = SK_FULL;
                    skid_d  = i_data;
                end else if (pop) begin
                    state_d = SK_EMPTY;
                end
            end
            SK_FULL: if (pop) begin
                state_d = SK_ONE;
                main_d  = skid_q;
            end
            default: state_d = SK_EMPTY;
        endcase
        if (i_flush) state_d = SK_EMPTY;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= SK_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != SK_FULL);
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: result select, skid-buffered handshake, gated write/forward.
// Optional load extraction when MEM_WB_LOADEXT_EN is defined.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int PC_STEP = 4
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_flush,
    input  logic [DW-1:0] i_data_pc4,
    input  logic [DW-1:0] i_data_alures,
    input  logic [DW-1:0] i_data_memout,
    input  logic [DW-1:0] i_data_hi,
    input  logic [DW-1:0] i_data_lo,
    input  logic [1:0]    i_con_ressel,
    input  logic          i_con_memtoreg,
    input  logic          i_con_regwrite,
    input  logic          i_con_memread,
    input  logic [RW-1:0] i_addr_regdst,
    input  logic [RW-1:0] i_addr_rt,
    input  logic [1:0]    i_con_ldsize,
    input  logic          i_con_ldsigned,
    input  logic [1:0]    i_addr_lsb,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data_alures,
    output logic [DW-1:0] o_data_memout,
    output logic [RW-1:0] o_addr_regdst,
    output logic [RW-1:0] o_addr_rt,
    output logic          o_con_memtoreg,
    output logic          o_con_memread,
    output logic          o_con_regwrite,
    output logic          o_fw_en,
    output logic [DW-1:0] o_fw_data
);

    localparam int PW = $bits(mem_wb_pl_t);

    mem_wb_pl_t    pl_in, pl_out;
    logic [DW-1:0] res, mem_x;

    always_comb begin
        case (ressel_e'(i_con_ressel))
            RES_ALU:  res = i_data_alures;
            RES_LINK: res = i_data_pc4 + DW'(PC_STEP);
            RES_LO:   res = i_data_lo;
            default:  res = i_data_hi;
        endcase
    end

`ifdef MEM_WB_LOADEXT_EN
    assign mem_x = i_con_memread
                 ? DW'(ld_extract(DW_DEF'(i_data_memout), i_con_ldsize, i_con_ldsigned, i_addr_lsb))
                 : i_data_memout;
`else
    logic unused_ldext;
    assign unused_ldext = ^{i_con_ldsize, i_con_ldsigned, i_addr_lsb};
    assign mem_x = i_data_memout;
`endif

    always_comb begin
        pl_in          = '0;
        pl_in.alures   = DW_DEF'(res);
        pl_in.memout   = DW_DEF'(mem_x);
        pl_in.regdst   = RW_DEF'(i_addr_regdst);
        pl_in.rt       = RW_DEF'(i_addr_rt);
        pl_in.memtoreg = i_con_memtoreg;
        pl_in.memread  = i_con_memread;
        pl_in.regwrite = i_con_regwrite;
    end

    mem_wb_skid #(.PW(PW)) u_skid (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (pl_in),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (pl_out)
    );

    // Payload may be stale after a flush; only the valid-gated controls matter then.
    assign o_data_alures  = DW'(pl_out.alures);
    assign o_data_memout  = DW'(pl_out.memout);
    assign o_addr_regdst  = RW'(pl_out.regdst);
    assign o_addr_rt      = RW'(pl_out.rt);
    assign o_con_memtoreg = pl_out.memtoreg;
    assign o_con_memread  = pl_out.memread;
    assign o_con_regwrite = pl_out.regwrite & o_valid;
    assign o_fw_en        = o_valid & pl_out.regwrite & (|pl_out.regdst);
    assign o_fw_data      = pl_out.memtoreg ? o_data_memout : o_data_alures;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, link/LO/HI select, stall, flush, forwarding, load ext.
module tb_mem_wb_stage;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_valid, o_ready, i_flush;
    logic [31:0] i_data_pc4, i_data_alures, i_data_memout, i_data_hi, i_data_lo;
    logic [1:0]  i_con_ressel;
    logic        i_con_memtoreg, i_con_regwrite, i_con_memread;
    logic [4:0]  i_addr_regdst, i_addr_rt;
    logic [1:0]  i_con_ldsize;
    logic        i_con_ldsigned;
    logic [1:0]  i_addr_lsb;
    logic        o_valid, i_ready;
    logic [31:0] o_data_alures, o_data_memout, o_fw_data;
    logic [4:0]  o_addr_regdst, o_addr_rt;
    logic        o_con_memtoreg, o_con_memread, o_con_regwrite, o_fw_en;

    int n_chk = 0;
    int n_pass = 0;

    mem_wb_stage dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_data_pc4(i_data_pc4), .i_data_alures(i_data_alures), .i_data_memout(i_data_memout),
        .i_data_hi(i_data_hi), .i_data_lo(i_data_lo), .i_con_ressel(i_con_ressel),
        .i_con_memtoreg(i_con_memtoreg), .i_con_regwrite(i_con_regwrite),
        .i_con_memread(i_con_memread), .i_addr_regdst(i_addr_regdst), .i_addr_rt(i_addr_rt),
        .i_con_ldsize(i_con_ldsize), .i_con_ldsigned(i_con_ldsigned), .i_addr_lsb(i_addr_lsb),
        .o_valid(o_valid), .i_ready(i_ready), .o_data_alures(o_data_alures),
        .o_data_memout(o_data_memout), .o_addr_regdst(o_addr_regdst), .o_addr_rt(o_addr_rt),
        .o_con_memtoreg(o_con_memtoreg), .o_con_memread(o_con_memread),
        .o_con_regwrite(o_con_regwrite), .o_fw_en(o_fw_en), .o_fw_data(o_fw_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_nrst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_data_pc4 = '0; i_data_alures = '0; i_data_memout = '0;
        i_data_hi = 32'h2222_2222; i_data_lo = 32'h1111_1111;
        i_con_ressel = 2'b00; i_con_memtoreg = 1'b0; i_con_regwrite = 1'b0;
        i_con_memread = 1'b0; i_addr_regdst = 5'd0; i_addr_rt = 5'd0;
        i_con_ldsize = 2'b10; i_con_ldsigned = 1'b0; i_addr_lsb = 2'b00;
        #12;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_alures", o_data_alures, 32'd0);
        chk("rst_regwrite", {31'b0, o_con_regwrite}, 32'd0);
        @(negedge i_clk); i_nrst = 1'b1;
        step();
        chk("post_rst_ready", {31'b0, o_ready}, 32'd1);

        // link address
        i_valid = 1'b1; i_con_ressel = 2'b01; i_data_pc4 = 32'h0040_0010;
        i_con_regwrite = 1'b1; i_addr_regdst = 5'd31; i_addr_rt = 5'd7;
        step();
        chk("link_valid", {31'b0, o_valid}, 32'd1);
        chk("link_res", o_data_alures, 32'h0040_0014);
        chk("link_ready", {31'b0, o_ready}, 32'd1);
        chk("link_fw_en", {31'b0, o_fw_en}, 32'd1);
        chk("link_fw_data", o_fw_data, 32'h0040_0014);
        chk("link_rt", {27'b0, o_addr_rt}, 32'd7);

        // back-to-back LO/HI, no bubbles
        for (int k = 0; k < 4; k++) begin
            i_con_ressel = (k % 2 == 0) ? 2'b10 : 2'b11;
            step();
            chk("b2b_valid", {31'b0, o_valid}, 32'd1);
            chk("b2b_res", o_data_alures, (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
        end
        i_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, o_valid}, 32'd0);

        // stall for three cycles with the producer holding its beat
        i_con_ressel = 2'b00; i_valid = 1'b1; i_data_alures = 32'h100;
        step();
        chk("st0_res", o_data_alures, 32'h100);
        i_data_alures = 32'h101; i_ready = 1'b0;
        step();
        chk("st1_res", o_data_alures, 32'h100);
        chk("st1_ready", {31'b0, o_ready}, 32'd0);
        i_data_alures = 32'h102;
        step();
        chk("st2_res", o_data_alures, 32'h100);
        chk("st2_ready", {31'b0, o_ready}, 32'd0);
        step();
        chk("st3_res", o_data_alures, 32'h100);
        chk("st3_valid", {31'b0, o_valid}, 32'd1);
        i_ready = 1'b1;
        step();
        chk("rel1_res", o_data_alures, 32'h101);
        chk("rel1_ready", {31'b0, o_ready}, 32'd1);
        step();
        chk("rel2_res", o_data_alures, 32'h102);
        i_valid = 1'b0;
        step();
        chk("rel_drain", {31'b0, o_valid}, 32'd0);

        // fill to FULL then flush with a valid input present
        i_valid = 1'b1; i_ready = 1'b0; i_data_alures = 32'h200;
        step();
        i_data_alures = 32'h201;
        step();
        chk("full_ready", {31'b0, o_ready}, 32'd0);
        chk("full_valid", {31'b0, o_valid}, 32'd1);
        i_flush = 1'b1; i_data_alures = 32'h202;
        step();
        chk("fl_valid", {31'b0, o_valid}, 32'd0);
        chk("fl_regwrite", {31'b0, o_con_regwrite}, 32'd0);
        chk("fl_fw_en", {31'b0, o_fw_en}, 32'd0);
        chk("fl_ready", {31'b0, o_ready}, 32'd1);
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        step();
        chk("fl_dropped", {31'b0, o_valid}, 32'd0);

        // regdst 0 never forwards
        i_valid = 1'b1; i_addr_regdst = 5'd0; i_con_memtoreg = 1'b1;
        i_data_memout = 32'hDEAD_BEEF; i_data_alures = 32'h1234_5678;
        step();
        chk("r0_fw_en", {31'b0, o_fw_en}, 32'd0);
        chk("r0_regwrite", {31'b0, o_con_regwrite}, 32'd1);
        chk("r0_fw_data", o_fw_data, 32'hDEAD_BEEF);
        chk("r0_alures", o_data_alures, 32'h1234_5678);

        // load extraction
        i_con_memread = 1'b1; i_data_memout = 32'h80FF_7F01; i_addr_regdst = 5'd4;
        i_con_ldsize = 2'b00; i_con_ldsigned = 1'b1; i_addr_lsb = 2'd3;
        step();
`ifdef MEM_WB_LOADEXT_EN
        chk("ld_byte_s", o_data_memout, 32'hFFFF_FF80);
`else
        chk("ld_byte_raw", o_data_memout, 32'h80FF_7F01);
`endif
        chk("ld_memread", {31'b0, o_con_memread}, 32'd1);
        i_con_ldsize = 2'b01; i_con_ldsigned = 1'b0; i_addr_lsb = 2'd2;
        step();
`ifdef MEM_WB_LOADEXT_EN
        chk("ld_half_u", o_data_memout, 32'h0000_80FF);
`else
        chk("ld_half_raw", o_data_memout, 32'h80FF_7F01);
`endif
        chk("ld_fw_en", {31'b0, o_fw_en}, 32'd1);

        // reset mid-transfer loses the entry
        i_ready = 1'b0;
        step();
        i_nrst = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, o_valid}, 32'd0);
        chk("mrst_ready", {31'b0, o_ready}, 32'd1);
        chk("mrst_memout", o_data_memout, 32'd0);
        i_valid = 1'b0;
        @(negedge i_clk); i_nrst = 1'b1;
        step();
        chk("mrst_after", {31'b0, o_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline boundary for the MIPS-style core; successor to the single-register MEM/WB stage.
- Selects the write-back result in MEM: ALU result, link address (PC+8), LO or HI.
- Registers the result with memory read data, destination register and control, and exports forwarding information.
- Adds a valid/ready handshake with a 2-entry skid buffer (registered o_ready), flush, and valid-gated register write.

Parameters:
- DW, 32, data width of all datapath buses.
- RW, 5, register-address width.
- PC_STEP, 4, constant added to i_data_pc4 to form the link address.

Ports:
- i_clk  in  1  clock, rising edge.
- i_nrst  in  1  reset; asynchronous, active-low.
- i_valid  in  1  MEM stage presents a valid instruction.
- o_ready  out  1  stage can accept this cycle; registered.
- i_flush  in  1  kill all held and incoming entries.
- i_data_pc4  in  DW  PC+4 of the instruction.
- i_data_alures  in  DW  ALU result.
- i_data_memout  in  DW  data-memory read word.
- i_data_hi  in  DW  HI register value.
- i_data_lo  in  DW  LO register value.
- i_con_ressel  in  2  result select: 00 ALU, 01 link, 10 LO, 11 HI.
- i_con_memtoreg  in  1  write back memory data.
- i_con_regwrite  in  1  instruction writes the register file.
- i_con_memread  in  1  instruction is a load.
- i_addr_regdst  in  RW  destination register.
- i_addr_rt  in  RW  rt field.
- i_con_ldsize  in  2  00 byte, 01 half, 10 word.
- i_con_ldsigned  in  1  sign-extend a sub-word load.
- i_addr_lsb  in  2  byte offset of the load.
- o_valid  out  1  WB entry valid.
- i_ready  in  1  WB accepts this cycle.
- o_data_alures  out  DW  registered selected result.
- o_data_memout  out  DW  registered (extracted) memory data.
- o_addr_regdst  out  RW  registered destination.
- o_addr_rt  out  RW  registered rt.
- o_con_memtoreg  out  1  registered.
- o_con_memread  out  1  registered.
- o_con_regwrite  out  1  registered regwrite AND o_valid.
- o_fw_en  out  1  o_valid & regwrite & (regdst != 0).
- o_fw_data  out  DW  memtoreg ? memout : alures, head entry.

Behaviour:
- Reset: all storage and outputs cleared to 0; o_ready = 1 one clock after reset is released (value held at 1 during reset).
- Result mux (combinational, pre-register): 00 → alures; 01 → pc4 + PC_STEP, modulo 2^DW; 10 → lo; 11 → hi.
- Accept condition: i_valid & o_ready & ~i_flush. Pop condition: o_valid & i_ready.
- Storage is a main slot (drives the outputs) plus a skid slot. o_ready = ~skid_valid, registered.
- FSM EMPTY: accept → ONE.
- FSM ONE: accept & pop → ONE, main reloaded. Accept without pop → FULL, data goes to skid. Pop without accept → EMPTY.
- FSM FULL: pop → ONE, skid moves to main. No accept is possible in FULL.
- Latency: 1 cycle from accept to o_valid when the stage was empty or popping. Throughput: 1/cycle while i_ready = 1.
- Output hold: payload stays stable while o_valid & ~i_ready.
- Flush: next state is EMPTY regardless of valid, ready or pop; any input in the same cycle is dropped. Payload may hold stale data but o_valid = 0, o_con_regwrite = 0 and o_fw_en = 0.
- Write gating: regwrite and fw outputs are forced to 0 whenever o_valid = 0. A regdst of 0 never forwards.
- Reset asserted mid-transfer: entries are lost, no partial state is retained.

Optional Feature:
- Macro MEM_WB_LOADEXT_EN.
- Defined: memout passes through load extraction before registration when memread = 1. Byte = word >> (8*lsb) [7:0]; half = word >> (16*lsb[1]) [15:0]; each is sign- or zero-extended per ldsigned. Word and non-load instructions pass through unchanged.
- Undefined: memout is registered raw. i_con_ldsize, i_con_ldsigned and i_addr_lsb remain as ports and are ignored.

Decomposition:
- Package mem_wb_pkg:
  - enum ressel_e (RES_ALU, RES_LINK, RES_LO, RES_HI).
  - enum ldsize_e (LD_B, LD_H, LD_W).
  - payload struct typedef mem_wb_pl_t, parametrised through package constants DW_DEF and RW_DEF.
- Sub-module mem_wb_skid: generic 2-entry skid buffer, parameter PW (payload width), with valid/ready/flush ports. mem_wb_stage instantiates it around the packed payload.

Test Plan:
- Reset then i_valid = 1, ressel = 01, pc4 = 0x0040_0010, i_ready = 1 → next cycle o_valid = 1, o_data_alures = 0x0040_0014, o_ready = 1.
- Four back-to-back accepts with ressel 10/11 (lo = 0x1111_1111, hi = 0x2222_2222), i_ready = 1 → outputs alternate each cycle, no bubble.
- i_ready = 0 for 3 cycles during streaming → o_ready = 0 after the second held entry, no loss or duplication, order preserved after release.
- FULL state + i_flush = 1 with i_valid = 1 → next cycle o_valid = 0, o_con_regwrite = 0, o_fw_en = 0, o_ready = 1.
- regwrite = 1, regdst = 0, memtoreg = 1, memout = 0xDEAD_BEEF → o_fw_en = 0, o_con_regwrite = 1, o_fw_data = 0xDEAD_BEEF.
- With MEM_WB_LOADEXT_EN: memread, memout = 0x80FF_7F01, byte signed, lsb = 3 → o_data_memout = 0xFFFF_FF80. Half unsigned, lsb = 2 → 0x0000_80FF. Without the macro → 0x80FF_7F01.
